// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: issues FIFO reads under a 3-slot credit limit and
// replays the words on a valid/ready stream with burst framing.
module fifo_stream_reader #(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [15:0]       words_out
);

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  logic [DATA_W-1:0] entry0, entry1, entry2;
  logic [1:0]        head, tail, occ;
  logic              inflight;
  logic [7:0]        beat_cnt;
  logic [2:0]        credit_used;
  logic              push, pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A read is only issued if its word is guaranteed a free slot on arrival.
  always_comb begin
    credit_used = {1'b0, occ} + {2'b00, inflight};
    fifo_rd_en  = en && !fifo_empty && (credit_used < 3'd3) && !rst;
    m_valid     = (occ != 2'd0);
    case (head)
      2'd0:    m_data = entry0;
      2'd1:    m_data = entry1;
      default: m_data = entry2;
    endcase
    m_last = m_valid && (beat_cnt == LAST_BEAT);
    push   = inflight;
    pop    = m_valid && m_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      occ       <= '0;
      inflight  <= 1'b0;
      beat_cnt  <= '0;
      words_out <= '0;
      entry0    <= '0;
      entry1    <= '0;
      entry2    <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (push) begin
        case (tail)
          2'd0:    entry0 <= fifo_data;
          2'd1:    entry1 <= fifo_data;
          default: entry2 <= fifo_data;
        endcase
        tail <= next_ptr(tail);
      end
      if (pop) begin
        head      <= next_ptr(head);
        words_out <= words_out + 16'd1;
        beat_cnt  <= m_last ? '0 : beat_cnt + 8'd1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO model feeds the DUT and a
// scoreboard checks ordering, framing, counters and credit limits.
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, en = 1'b0, m_ready = 1'b0;
  logic        fifo_empty, fifo_rd_en, m_valid, m_last;
  logic [31:0] fifo_data = '0, m_data;
  logic [15:0] words_out;

  logic        en2 = 1'b0, m_ready2 = 1'b0;
  logic        rd_en2, m_valid2, m_last2;
  logic [31:0] fifo_data2 = '0, src2 = '0, m_data2;
  logic [15:0] words_out2;

  fifo_stream_reader #(.DATA_W(32), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .words_out(words_out)
  );

  fifo_stream_reader #(.DATA_W(32), .BURST_LEN(1)) dut_b1 (
    .clk(clk), .rst(rst), .en(en2), .fifo_empty(1'b0), .fifo_data(fifo_data2),
    .fifo_rd_en(rd_en2), .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2),
    .m_last(m_last2), .words_out(words_out2)
  );

  // Behavioural FIFO: registered read data, empty flag from post-edge count.
  logic        wr_req = 1'b0;
  logic [31:0] wr_word = '0;
  logic [31:0] fq[$];
  int          fcount = 0;
  int          fc_next;
  assign fifo_empty = (fcount == 0);

  always @(posedge clk) begin
    fc_next = fcount;
    if (fifo_rd_en && fq.size() > 0) begin
      fifo_data <= fq.pop_front();
      fc_next = fc_next - 1;
    end
    if (wr_req) begin
      fq.push_back(wr_word);
      fc_next = fc_next + 1;
    end
    fcount <= fc_next;
  end

  always @(posedge clk) begin
    if (rd_en2) begin
      fifo_data2 <= src2;
      src2       <= src2 + 32'd1;
    end
  end

  // Scoreboard: every written word comes out once, in order; beat position
  // is the handshake count since reset modulo the burst length.
  logic [31:0] exp_q[$];
  int          checks = 0, errors = 0, hs_cnt = 0, issued = 0;
  bit          stall_prev = 1'b0;
  logic [31:0] hold_data = '0;
  logic        hold_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit do_wr, input logic [31:0] wd);
    #1;
    if (stall_prev) begin
      chk("hold_data", m_data, hold_data);
      chk("hold_last", 32'(m_last), 32'(hold_last));
    end
    stall_prev = m_valid && !m_ready;
    hold_data  = m_data;
    hold_last  = m_last;
    chk("rd_en_while_empty", 32'(fifo_rd_en && fifo_empty), 32'd0);
    if (fifo_rd_en) issued++;
    chk("outstanding_le3", (issued - hs_cnt <= 3) ? 32'd1 : 32'd0, 32'd1);
    if (!m_valid) begin
      chk("last_unqualified", 32'(m_last), 32'd0);
    end else if (m_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_word", 32'(m_valid), 32'd0);
      end else begin
        chk("m_data", m_data, exp_q.pop_front());
        chk("m_last", 32'(m_last), (hs_cnt % 4 == 3) ? 32'd1 : 32'd0);
      end
      hs_cnt++;
    end
    wr_req  = do_wr;
    wr_word = wd;
    if (do_wr) exp_q.push_back(wd);
    @(posedge clk);
    @(negedge clk);
    wr_req = 1'b0;
    chk("words_out", 32'(words_out), 32'(hs_cnt % 65536));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    m_ready = 1'b1;
    while ((exp_q.size() != 0 || m_valid) && n < budget) begin
      tick(1'b0, '0);
      n++;
    end
    chk("drain_complete", 32'(exp_q.size()), 32'd0);
    chk("drain_idle", 32'(m_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rd_en_in_reset", 32'(fifo_rd_en), 32'd0);
    end
    chk("reset_m_valid", 32'(m_valid), 32'd0);
    chk("reset_m_last", 32'(m_last), 32'd0);
    chk("reset_m_data", m_data, 32'd0);
    chk("reset_words_out", 32'(words_out), 32'd0);
    hs_cnt     = 0;
    issued     = 0;
    stall_prev = 1'b0;
    rst        = 1'b0;
  endtask

  initial begin
    int          base_i, base_h, hs2, n;
    logic [31:0] first_w, exp2, w;

    // Reset with five words already sitting in the FIFO.
    en      = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      wr_req  = 1'b1;
      wr_word = 32'h50 + 32'(i);
      exp_q.push_back(wr_word);
      @(posedge clk);
      @(negedge clk);
      wr_req = 1'b0;
    end
    do_reset();
    #1;
    chk("first_rd_after_reset", 32'(fifo_rd_en), 32'd1);
    chk("no_valid_at_issue", 32'(m_valid), 32'd0);
    tick(1'b0, '0);
    chk("latency_n_plus_1", 32'(m_valid), 32'd0);
    tick(1'b0, '0);
    chk("latency_n_plus_2", 32'(m_valid), 32'd1);
    chk("latency_first_word", m_data, 32'h50);
    drain(20);

    // Streaming drain of A0..A7 from a fresh burst position.
    do_reset();
    en = 1'b0;
    for (int i = 0; i < 8; i++) tick(1'b1, 32'hA0 + 32'(i));
    en = 1'b1;
    #1;
    chk("stream_first_rd", 32'(fifo_rd_en), 32'd1);
    tick(1'b0, '0);
    tick(1'b0, '0);
    chk("stream_valid_after_2", 32'(m_valid), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("stream_gapless", 32'(m_valid), 32'd1);
      tick(1'b0, '0);
    end
    chk("stream_words_out", 32'(words_out), 32'd8);
    chk("stream_rd_idle", 32'(fifo_rd_en), 32'd0);
    drain(10);

    // Backpressure: ten words, consumer stalled for ten cycles.
    en = 1'b0;
    first_w = $urandom;
    tick(1'b1, first_w);
    for (int i = 1; i < 10; i++) tick(1'b1, $urandom);
    m_ready = 1'b0;
    en      = 1'b1;
    base_i  = issued;
    repeat (10) tick(1'b0, '0);
    chk("bp_reads_issued", 32'(issued - base_i), 32'd3);
    chk("bp_valid_held", 32'(m_valid), 32'd1);
    chk("bp_first_word_held", m_data, first_w);
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_gapless", 32'(m_valid), 32'd1);
      tick(1'b0, '0);
    end
    drain(10);

    // Intermittent empty: one word every third cycle.
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, $urandom);
      tick(1'b0, '0);
      tick(1'b0, '0);
    end
    drain(10);

    // en dropped the cycle after a read; burst position must survive.
    en = 1'b0;
    for (int i = 0; i < 6; i++) tick(1'b1, $urandom);
    en = 1'b1;
    #1;
    chk("gate_rd_issued", 32'(fifo_rd_en), 32'd1);
    tick(1'b0, '0);
    en     = 1'b0;
    base_i = issued;
    base_h = hs_cnt;
    repeat (6) tick(1'b0, '0);
    chk("gate_no_new_reads", 32'(issued - base_i), 32'd0);
    chk("gate_inflight_delivered", 32'(hs_cnt - base_h), 32'd1);
    en = 1'b1;
    drain(30);

    // Randomised traffic with random enable and backpressure.
    for (int i = 0; i < 80; i++) begin
      en      = ($urandom_range(3) != 0);
      m_ready = ($urandom_range(2) != 0);
      w       = $urandom;
      tick((fcount < 12) && ($urandom_range(1) == 1), w);
    end
    en = 1'b1;
    drain(40);

    // Counter wrap on the single-beat-burst instance.
    en2      = 1'b1;
    m_ready2 = 1'b1;
    hs2      = 0;
    n        = 0;
    exp2     = '0;
    while (hs2 < 65538 && n < 70000) begin
      if (m_valid2) begin
        chk("wrap_last", 32'(m_last2), 32'd1);
        chk("wrap_data", m_data2, exp2);
        exp2 = exp2 + 32'd1;
        hs2++;
        @(posedge clk);
        @(negedge clk);
        if (hs2 == 65536) chk("wrap_zero", 32'(words_out2), 32'd0);
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
      n++;
    end
    chk("wrap_handshakes", 32'(hs2), 32'd65538);
    chk("wrap_final", 32'(words_out2), 32'd2);
    en2 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
